// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Included by the interface, the arbiter sub-module and the top.
package reg_file_pkg;

  localparam int DEF_ADW  = 5;
  localparam int DEF_DPW  = 32;
  localparam int NUM_REGS = 2 ** DEF_ADW;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/reg_file_wb_arbiter_if.sv
// Writeback requester bundle plus the register-file write port.
// Requesters sit on the master side, the arbiter on the slave side.
interface reg_file_wb_arbiter_if
  import reg_file_pkg::*;
#(
  parameter int ADW = DEF_ADW,
  parameter int DPW = DEF_DPW
) ();

  logic           req0_valid_i;
  logic           req0_ready_o;
  logic [ADW-1:0] req0_addr_i;
  logic [DPW-1:0] req0_data_i;

  logic           req1_valid_i;
  logic           req1_ready_o;
  logic [ADW-1:0] req1_addr_i;
  logic [DPW-1:0] req1_data_i;

  logic [ADW-1:0] addr_3_o;
  logic           we_o;
  logic [DPW-1:0] wd_3_o;
  logic           grant_o;
  logic           init_done_o;

  modport master (
    output req0_valid_i, req0_addr_i, req0_data_i,
    output req1_valid_i, req1_addr_i, req1_data_i,
    input  req0_ready_o, req1_ready_o,
    input  addr_3_o, we_o, wd_3_o, grant_o, init_done_o
  );

  modport slave (
    input  req0_valid_i, req0_addr_i, req0_data_i,
    input  req1_valid_i, req1_addr_i, req1_data_i,
    output req0_ready_o, req1_ready_o,
    output addr_3_o, we_o, wd_3_o, grant_o, init_done_o
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a last-grant pointer.
// The pointer moves only when a grant is actually taken.
module rr_arb2
  import reg_file_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] ready_o
);

  req_id_t ptr_q;

  always_comb begin
    ready_o = '0;
    if (en_i) begin
      unique case (valid_i)
        2'b01:   ready_o = 2'b01;
        2'b10:   ready_o = 2'b10;
        2'b11:   ready_o = ptr_q ? 2'b01 : 2'b10;
        default: ready_o = '0;
      endcase
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b1;
    end else if (|(valid_i & ready_o)) begin
      ptr_q <= ready_o[1];
    end
  end

endmodule

// File: rtl/reg_file_wb_arbiter.sv
// Shares the register-file write port between ALU and LSU writeback.
// Zeroes x1..xN-1 after reset before any request is accepted.
module reg_file_wb_arbiter
  import reg_file_pkg::*;
#(
  parameter int ADW = DEF_ADW,
  parameter int DPW = DEF_DPW
) (
  input logic                  clk_i,
  input logic                  rst_i,
  reg_file_wb_arbiter_if.slave bus
);

  localparam logic [ADW-1:0] LAST = '1;

  state_e         state_q, state_d;
  logic [ADW-1:0] cnt_q, cnt_d;
  logic [ADW-1:0] addr_q, addr_d;
  logic [DPW-1:0] data_q, data_d;
  logic           we_q, we_d;
  logic           done_q, done_d;
  req_id_t        grant_q, grant_d;

  logic [1:0]     valid, ready, hs;
  req_id_t        hs_id;
  logic [ADW-1:0] sel_addr;
  logic [DPW-1:0] sel_data;

  assign valid = {bus.req1_valid_i, bus.req0_valid_i};

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (done_q),
    .valid_i (valid),
    .ready_o (ready)
  );

  assign hs       = valid & ready;
  assign hs_id    = hs[1];
  assign sel_addr = hs_id ? bus.req1_addr_i : bus.req0_addr_i;
  assign sel_data = hs_id ? bus.req1_data_i : bus.req0_data_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    grant_d = grant_q;
    done_d  = done_q;
    we_d    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = '0;
        cnt_d  = cnt_q + ADW'(1);
        if (cnt_q == LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        done_d = 1'b1;
        if (|hs) begin
          grant_d = hs_id;
          // x0 is hardwired zero: take the handshake, skip the write.
          if (sel_addr != '0) begin
            we_d   = 1'b1;
            addr_d = sel_addr;
            data_d = sel_data;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= ADW'(1);
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      grant_q <= grant_d;
    end
  end

  assign bus.req0_ready_o = ready[0];
  assign bus.req1_ready_o = ready[1];
  assign bus.addr_3_o     = addr_q;
  assign bus.we_o         = we_q;
  assign bus.wd_3_o       = data_q;
  assign bus.grant_o      = grant_q;
  assign bus.init_done_o  = done_q;

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Directed bench for reg_file_wb_arbiter with a behavioural reg file.
// Vectors are applied one per cycle; write-port results checked next cycle.
module tb_reg_file_wb_arbiter;
  import reg_file_pkg::*;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        g;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  reg_file_wb_arbiter_if #(.ADW(DEF_ADW), .DPW(DEF_DPW)) bus ();

  reg_file_wb_arbiter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] rf [NUM_REGS];

  always @(posedge clk) begin
    if (bus.we_o && bus.addr_3_o != 5'd0) rf[bus.addr_3_o] <= bus.wd_3_o;
  end

  logic        p0 = 1'b0, p1 = 1'b0;
  logic [4:0]  pa0, pa1;
  logic [31:0] pd0, pd1;

  always @(posedge clk) begin
    if (p0 && bus.req0_valid_i)
      assert (bus.req0_addr_i == pa0 && bus.req0_data_i == pd0)
        else $error("req0 changed while waiting");
    if (p1 && bus.req1_valid_i)
      assert (bus.req1_addr_i == pa1 && bus.req1_data_i == pd1)
        else $error("req1 changed while waiting");
    p0  <= bus.req0_valid_i && !bus.req0_ready_o;
    p1  <= bus.req1_valid_i && !bus.req1_ready_o;
    pa0 <= bus.req0_addr_i;
    pd0 <= bus.req0_data_i;
    pa1 <= bus.req1_addr_i;
    pd1 <= bus.req1_data_i;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req0_valid_i = v.v0;
    bus.req0_addr_i  = v.a0;
    bus.req0_data_i  = v.d0;
    bus.req1_valid_i = v.v1;
    bus.req1_addr_i  = v.a1;
    bus.req1_data_i  = v.d1;
  endtask

  vec_t tbl [12];
  vec_t idle;

  initial begin
    idle = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
    tbl[0]  = '{1'b1, 5'd6, 32'h10101010, 1'b1, 5'd7, 32'h20202020,
                1'b1, 1'b0, 1'b1, 5'd6, 32'h10101010, 1'b0};
    tbl[1]  = '{1'b1, 5'd6, 32'h11111111, 1'b1, 5'd7, 32'h20202020,
                1'b0, 1'b1, 1'b1, 5'd7, 32'h20202020, 1'b1};
    tbl[2]  = '{1'b1, 5'd6, 32'h11111111, 1'b1, 5'd7, 32'h22222222,
                1'b1, 1'b0, 1'b1, 5'd6, 32'h11111111, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h22222222,
                1'b0, 1'b1, 1'b1, 5'd7, 32'h22222222, 1'b1};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b0, 1'b0, 5'd7, 32'h22222222, 1'b0};
    tbl[5]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0};
    tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF,
                1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0};
    tbl[7]  = '{1'b1, 5'd8, 32'h12345678, 1'b1, 5'd9, 32'h9ABCDEF0,
                1'b1, 1'b0, 1'b1, 5'd8, 32'h12345678, 1'b0};
    tbl[8]  = '{1'b1, 5'd10, 32'h0000CAFE, 1'b1, 5'd9, 32'h9ABCDEF0,
                1'b0, 1'b1, 1'b1, 5'd9, 32'h9ABCDEF0, 1'b1};
    tbl[9]  = '{1'b1, 5'd10, 32'h0000CAFE, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b0, 1'b1, 5'd10, 32'h0000CAFE, 1'b0};
    tbl[10] = '{1'b1, 5'd11, 32'h00000001, 1'b1, 5'd12, 32'h00000002,
                1'b0, 1'b1, 1'b1, 5'd12, 32'h00000002, 1'b1};
    tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b0, 1'b0, 5'd12, 32'h00000002, 1'b0};

    drive(idle);
    bus.req0_valid_i = 1'b1;
    bus.req1_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(bus.we_o), 32'd0);
    chk("rst_addr", 32'(bus.addr_3_o), 32'd0);
    chk("rst_wd", bus.wd_3_o, 32'd0);
    chk("rst_grant", 32'(bus.grant_o), 32'd0);
    chk("rst_done", 32'(bus.init_done_o), 32'd0);
    chk("rst_ready", 32'({bus.req1_ready_o, bus.req0_ready_o}), 32'd0);
    drive(idle);
    rst = 1'b0;

    for (int i = 1; i < NUM_REGS; i++) begin
      @(negedge clk);
      chk("clr_we", 32'(bus.we_o), 32'd1);
      chk("clr_addr", 32'(bus.addr_3_o), 32'(i));
      chk("clr_wd", bus.wd_3_o, 32'd0);
      chk("clr_done", 32'(bus.init_done_o), 32'd0);
    end
    @(negedge clk);
    chk("init_done", 32'(bus.init_done_o), 32'd1);
    chk("init_we", 32'(bus.we_o), 32'd0);
    for (int i = 1; i < NUM_REGS; i++) chk("clr_rf", rf[i], 32'd0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_r0", i), 32'(bus.req0_ready_o), 32'(tbl[i].r0));
      chk($sformatf("v%0d_r1", i), 32'(bus.req1_ready_o), 32'(tbl[i].r1));
      @(negedge clk);
      chk($sformatf("v%0d_we", i), 32'(bus.we_o), 32'(tbl[i].we));
      chk($sformatf("v%0d_addr", i), 32'(bus.addr_3_o), 32'(tbl[i].addr));
      chk($sformatf("v%0d_wd", i), bus.wd_3_o, tbl[i].data);
      if (tbl[i].we)
        chk($sformatf("v%0d_grant", i), 32'(bus.grant_o), 32'(tbl[i].g));
    end
    drive(idle);
    chk("rf5", rf[5], 32'hDEADBEEF);
    chk("rf6", rf[6], 32'h11111111);
    chk("rf7", rf[7], 32'h22222222);
    chk("rf8", rf[8], 32'h12345678);
    chk("rf9", rf[9], 32'h9ABCDEF0);
    chk("rf10", rf[10], 32'h0000CAFE);
    chk("rf11", rf[11], 32'h0);
    chk("rf12", rf[12], 32'h00000002);

    bus.req0_valid_i = 1'b1;
    bus.req0_addr_i  = 5'd13;
    bus.req0_data_i  = 32'h77;
    rst = 1'b1;
    #1;
    chk("inflight_r0", 32'(bus.req0_ready_o), 32'd1);
    @(negedge clk);
    drive(idle);
    chk("inflight_we", 32'(bus.we_o), 32'd0);
    chk("inflight_done", 32'(bus.init_done_o), 32'd0);
    rst = 1'b0;

    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("part_addr", 32'(bus.addr_3_o), 32'(i));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midclr_we", 32'(bus.we_o), 32'd0);
    rst = 1'b0;
    bus.req0_valid_i = 1'b1;
    bus.req0_addr_i  = 5'd14;
    bus.req0_data_i  = 32'hABCD0123;
    for (int i = 1; i < NUM_REGS; i++) begin
      @(negedge clk);
      chk("reclr_addr", 32'(bus.addr_3_o), 32'(i));
      chk("reclr_we", 32'(bus.we_o), 32'd1);
      chk("reclr_r0", 32'(bus.req0_ready_o), 32'd0);
      chk("reclr_done", 32'(bus.init_done_o), 32'd0);
    end
    @(negedge clk);
    chk("redone", 32'(bus.init_done_o), 32'd1);
    chk("first_r0", 32'(bus.req0_ready_o), 32'd1);
    chk("first_we", 32'(bus.we_o), 32'd0);
    @(negedge clk);
    drive(idle);
    chk("late_we", 32'(bus.we_o), 32'd1);
    chk("late_addr", 32'(bus.addr_3_o), 32'd14);
    chk("late_wd", bus.wd_3_o, 32'hABCD0123);
    chk("late_grant", 32'(bus.grant_o), 32'd0);
    @(negedge clk);
    chk("late_nodup", 32'(bus.we_o), 32'd0);
    chk("rf14", rf[14], 32'hABCD0123);
    chk("rf5_cleared", rf[5], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
